// File: rtl/req_priority_encoder.sv
//------------------------------------------------------------------------------
// Module      : req_priority_encoder
// Description : Sequential N:W priority encoder. Request pulses are captured
//               into a sticky pending register; the highest-index pending
//               source is offered as a binary code with a valid/ack handshake,
//               and each source's pending bit is retired when its grant is
//               acknowledged.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module req_priority_encoder #(
    parameter int N = 8,   // number of request lines
    parameter int W = 3    // code width, 2**W must equal N
) (
    input  logic         clock,
    input  logic         clearb,
    input  logic [N-1:0] req,
    input  logic         enable,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] onehot,
    output logic [N-1:0] pend
);

    // Two-state grant machine; the state bit itself is the registered valid.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [N-1:0] c_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pend;
    logic [N-1:0]   w_pend_nxt;
    logic [W-1:0]   r_code;
    logic [W-1:0]   w_code_nxt;
    logic           w_valid;
    logic [N-1:0]   w_onehot;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_remain;

    // Highest set index wins; scanning upward lets later hits overwrite.
    function automatic logic [W-1:0] prio(input logic [N-1:0] x);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                p = W'(i);
            end
        end
        return p;
    endfunction

    assign w_valid  = (r_state == S_GRANT);
    assign w_onehot = w_valid ? (c_ONE << r_code) : '0;

    // Only an accepted grant retires its pending bit.
    assign w_clr    = (w_valid && ack) ? w_onehot : '0;

    // New requests are OR'd in after the clear so a request arriving in the
    // same cycle as the ack of that source is not lost.
    assign w_pend_nxt = (r_pend & ~w_clr) | req;

    // Candidates for a back-to-back grant: the current register minus the
    // source being acknowledged. Requests arriving this cycle are excluded.
    assign w_remain = r_pend & ~w_onehot;

    // Next-state and next-code selection for the grant machine.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        case (r_state)
            S_IDLE: begin
                if (enable && (|r_pend)) begin
                    w_state_nxt = S_GRANT;
                    w_code_nxt  = prio(r_pend);
                end
            end
            S_GRANT: begin
                // A grant already offered is held until acked, even if
                // enable drops in the meantime.
                if (ack) begin
                    if (enable && (|w_remain)) begin
                        w_code_nxt = prio(w_remain);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, code and pending registers; clearb drops everything at once.
    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    assign code   = r_code;
    assign valid  = w_valid;
    assign onehot = w_onehot;
    assign pend   = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_req_priority_encoder.sv
//------------------------------------------------------------------------------
// Module      : tb_req_priority_encoder
// Description : Directed bench for req_priority_encoder. Expected grants are
//               queued by the stimulus and consumed by a monitor at each
//               accepted handshake; register state is checked directly.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_req_priority_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clock;
    logic         clearb;
    logic [N-1:0] req;
    logic         enable;
    logic         ack;
    logic [W-1:0] code;
    logic         valid;
    logic [N-1:0] onehot;
    logic [N-1:0] pend;

    int n_total;
    int n_pass;
    int exp_q[$];

    req_priority_encoder #(.N(N), .W(W)) dut (
        .clock  (clock),
        .clearb (clearb),
        .req    (req),
        .enable (enable),
        .ack    (ack),
        .code   (code),
        .valid  (valid),
        .onehot (onehot),
        .pend   (pend)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge; inputs driven before this call are sampled at it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string name, input logic v, input logic [W-1:0] c,
                             input logic [N-1:0] p);
        chk({name, ".valid"}, 32'(valid), 32'(v));
        if (v) begin
            chk({name, ".code"},   32'(code),   32'(c));
            chk({name, ".onehot"}, 32'(onehot), 32'(8'h01 << c));
        end else begin
            chk({name, ".onehot"}, 32'(onehot), 32'h0);
        end
        chk({name, ".pend"}, 32'(pend), 32'(p));
    endtask

    // Monitor: every accepted handshake must match the next queued grant.
    initial begin
        forever begin
            @(negedge clock);
            if (clearb && valid && ack) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL mon.unexpected: got code %0d, expected no grant at %0t", code, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("mon.code",   32'(code),   32'(e));
                    chk("mon.onehot", 32'(onehot), 32'(8'h01 << e));
                end
            end
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        clearb  = 1'b0;
        req     = '0;
        enable  = 1'b0;
        ack     = 1'b0;
        repeat (2) tick();
        clearb = 1'b1;

        // Reset: flood requests, then pull clearb low mid-cycle.
        enable = 1'b1;
        req    = 8'hFF;
        repeat (3) tick();
        chk("rst.pre_valid", 32'(valid), 32'h1);
        #2 clearb = 1'b0;
        #1;
        chk("rst.code", 32'(code), 32'h0);
        chk_state("rst.async", 1'b0, 3'd0, 8'h00);
        req = 8'hA5;
        ack = 1'b1;
        repeat (2) tick();
        chk("rst.hold_code", 32'(code), 32'h0);
        chk_state("rst.hold", 1'b0, 3'd0, 8'h00);
        req = '0;
        ack = 1'b0;
        #2 clearb = 1'b1;
        tick();
        chk_state("rst.release", 1'b0, 3'd0, 8'h00);

        // Single pulse: pend at edge k, valid at k+1.
        req = 8'h04;
        tick();
        chk_state("single.k", 1'b0, 3'd0, 8'h04);
        req = '0;
        tick();
        chk_state("single.k1", 1'b1, 3'd2, 8'h04);
        exp_q.push_back(2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_state("single.done", 1'b0, 3'd0, 8'h00);

        // Priority burst with ack held: 7, 4, 0 back to back.
        req = 8'h91;
        tick();
        chk_state("burst.cap", 1'b0, 3'd0, 8'h91);
        req = '0;
        ack = 1'b1;
        exp_q.push_back(7);
        exp_q.push_back(4);
        exp_q.push_back(0);
        tick();
        chk_state("burst.g7", 1'b1, 3'd7, 8'h91);
        tick();
        chk_state("burst.g4", 1'b1, 3'd4, 8'h11);
        tick();
        chk_state("burst.g0", 1'b1, 3'd0, 8'h01);
        tick();
        ack = 1'b0;
        chk_state("burst.done", 1'b0, 3'd0, 8'h00);

        // Ack/request collision on source 5: re-granted via IDLE.
        req = 8'h20;
        tick();
        req = '0;
        tick();
        chk_state("coll.g5", 1'b1, 3'd5, 8'h20);
        exp_q.push_back(5);
        ack = 1'b1;
        req = 8'h20;
        tick();
        ack = 1'b0;
        req = '0;
        chk_state("coll.gap", 1'b0, 3'd0, 8'h20);
        tick();
        chk_state("coll.regrant", 1'b1, 3'd5, 8'h20);
        exp_q.push_back(5);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_state("coll.done", 1'b0, 3'd0, 8'h00);

        // Enable gating: capture continues, grants wait for enable.
        enable = 1'b0;
        req    = 8'h0A;
        tick();
        req = '0;
        repeat (4) tick();
        chk_state("en.blocked", 1'b0, 3'd0, 8'h0A);
        enable = 1'b1;
        tick();
        chk_state("en.g3", 1'b1, 3'd3, 8'h0A);
        enable = 1'b0;
        repeat (2) tick();
        chk_state("en.hold", 1'b1, 3'd3, 8'h0A);
        exp_q.push_back(3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_state("en.acked", 1'b0, 3'd0, 8'h02);
        enable = 1'b1;
        tick();
        chk_state("en.g1", 1'b1, 3'd1, 8'h02);
        exp_q.push_back(1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_state("en.done", 1'b0, 3'd0, 8'h00);

        // Reset mid-grant drops the grant and all pending requests.
        req = 8'h41;
        tick();
        req = '0;
        tick();
        chk_state("mid.g6", 1'b1, 3'd6, 8'h41);
        #2 clearb = 1'b0;
        #1;
        chk("mid.code", 32'(code), 32'h0);
        chk_state("mid.async", 1'b0, 3'd0, 8'h00);
        @(posedge clock);
        #2 clearb = 1'b1;
        repeat (3) tick();
        chk_state("mid.after", 1'b0, 3'd0, 8'h00);

        // Every queued grant must have been consumed.
        chk("sb.leftover", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
